led_panel_scan: RTL and testbench

//   Downstream of the pong frame composer. Scans the 64x64 1-bit framebuffer it produces onto a
//   HUB75-style LED panel with 1:32 multiplexing. Each scan step drives two rows at once: upper
//   row r on r1 and lower row r+32 on r2. Per step: fetch both rows, serially shift 64 columns,

---
 rtl/led_pkg.sv | 29 ++
 rtl/led_shift_pair.sv | 46 ++++
 rtl/led_panel_scan.sv | 188 ++++++++++++++++++
 tb/tb_led_panel_scan.sv | 437 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// led_pkg: shared scan-state type and default panel timing for the LED panel scanner.
package led_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetchU,
        StFetchL,
        StCapture,
        StShift,
        StBlank,
        StLatch,
        StDisplay
    } scan_state_t;

    // Rows driven on r2 sit this far below the rows driven on r1.
    localparam int unsigned PANEL_HALF         = 32;
    localparam int unsigned LED_COLS           = 64;
    localparam int unsigned LED_ROWS           = 2 * PANEL_HALF;
    localparam int unsigned LED_CLK_DIV        = 2;
    localparam int unsigned LED_BLANK_CYCLES   = 2;
    localparam int unsigned LED_DISPLAY_CYCLES = 256;

    function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/led_shift_pair.sv
// led_shift_pair: two column shift registers (upper and lower row of a scan step).
// Each loads a full row in parallel and shifts right, so bit 0 is the column on the wire.
module led_shift_pair
    import led_pkg::*;
#(
    parameter int unsigned COLS = LED_COLS
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load_u,
    input  logic            load_l,
    input  logic            shift,
    input  logic [COLS-1:0] din,
    output logic            r1,
    output logic            r2
);

    logic [COLS-1:0] upper_q;
    logic [COLS-1:0] lower_q;

    // Upper row: parallel load, then zero-filled right shift so the lines idle low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            upper_q <= '0;
        end else if (load_u) begin
            upper_q <= din;
        end else if (shift) begin
            upper_q <= {1'b0, upper_q[COLS-1:1]};
        end
    end

    // Lower row: same behaviour, loaded one cycle later from the second fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lower_q <= '0;
        end else if (load_l) begin
            lower_q <= din;
        end else if (shift) begin
            lower_q <= {1'b0, lower_q[COLS-1:1]};
        end
    end

    assign r1 = upper_q[0];
    assign r2 = lower_q[0];

endmodule

// File: rtl/led_panel_scan.sv
// led_panel_scan: scans a 64x64 1-bit framebuffer onto a 1:32 multiplexed HUB75-style panel.
// Per step: fetch upper/lower rows, shift COLS columns, blank, latch, then display.
// Optional feature macro: LED_SCAN_BRIGHTNESS_EN adds a 3-bit brightness input that scales
// the display on-time to (brightness+1)/8 of DISPLAY_CYCLES.
module led_panel_scan
    import led_pkg::*;
#(
    parameter int unsigned COLS           = LED_COLS,
    parameter int unsigned ROWS           = LED_ROWS,
    parameter int unsigned CLK_DIV        = LED_CLK_DIV,
    parameter int unsigned BLANK_CYCLES   = LED_BLANK_CYCLES,
    parameter int unsigned DISPLAY_CYCLES = LED_DISPLAY_CYCLES
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
`ifdef LED_SCAN_BRIGHTNESS_EN
    input  logic [2:0]                brightness,
`endif
    output logic [$clog2(ROWS)-1:0]   fb_addr,
    input  logic [COLS-1:0]           fb_data,
    output logic                      panel_r1,
    output logic                      panel_r2,
    output logic                      panel_clk,
    output logic                      panel_lat,
    output logic                      panel_oe_n,
    output logic [$clog2(ROWS/2)-1:0] panel_addr,
    output logic                      frame_start
);

    localparam int unsigned HALF      = ROWS / 2;
    localparam int unsigned FB_AW     = $clog2(ROWS);
    localparam int unsigned ROW_W     = $clog2(HALF);
    localparam int unsigned SHIFT_LEN = COLS * 2 * CLK_DIV;
    localparam int unsigned TIMER_MAX = max3(SHIFT_LEN, BLANK_CYCLES, DISPLAY_CYCLES);
    localparam int unsigned TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;
    localparam int unsigned PH_W      = $clog2(2 * CLK_DIV);

    scan_state_t        state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [PH_W-1:0]    phase_q, phase_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [TIMER_W-1:0] disp_last;
    logic               load_u;
    logic               load_l;
    logic               shift;

    // On-time of the DISPLAY state, expressed as the last timer value.
`ifdef LED_SCAN_BRIGHTNESS_EN
    logic [2:0]  bright_q;
    logic [31:0] disp_len;

    // Brightness is captured on LATCH so a step's on-time never changes mid-display.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bright_q <= 3'd7;
        end else if (state_q == StLatch) begin
            bright_q <= brightness;
        end
    end

    // Scale DISPLAY_CYCLES by (brightness+1)/8, never below one cycle.
    always_comb begin
        disp_len = ((32'(bright_q) + 32'd1) * DISPLAY_CYCLES) >> 3;
        if (disp_len == 32'd0) begin
            disp_len = 32'd1;
        end
        disp_last = TIMER_W'(disp_len - 32'd1);
    end
`else
    // Fixed on-time.
    always_comb begin
        disp_last = TIMER_W'(DISPLAY_CYCLES - 1);
    end
`endif

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; timed states exit on the last timer value.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (enable) state_d = StFetchU;
            StFetchU:  state_d = StFetchL;
            StFetchL:  state_d = StCapture;
            StCapture: state_d = StShift;
            StShift:   if (timer_q == TIMER_W'(SHIFT_LEN - 1)) state_d = StBlank;
            StBlank:   if (timer_q == TIMER_W'(BLANK_CYCLES - 1)) state_d = StLatch;
            StLatch:   state_d = StDisplay;
            StDisplay: if (timer_q == disp_last) state_d = enable ? StFetchU : StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // FSM outputs and datapath strobes, decoded from the current state.
    always_comb begin
        fb_addr     = FB_AW'(row_q);
        panel_clk   = 1'b0;
        panel_lat   = 1'b0;
        panel_oe_n  = 1'b1;
        frame_start = 1'b0;
        load_u      = 1'b0;
        load_l      = 1'b0;
        shift       = 1'b0;
        case (state_q)
            StFetchU:  frame_start = (row_q == '0);
            StFetchL: begin
                fb_addr = FB_AW'(row_q) + FB_AW'(HALF);
                load_u  = 1'b1;
            end
            StCapture: load_l = 1'b1;
            StShift: begin
                // Low half of the period then high half; data advances as the clock falls.
                panel_clk = (phase_q >= PH_W'(CLK_DIV));
                shift     = (phase_q == PH_W'(2 * CLK_DIV - 1));
            end
            StLatch:   panel_lat = 1'b1;
            StDisplay: panel_oe_n = 1'b0;
            default: ;
        endcase
    end

    // Timer, shift-clock phase and row counter next-state.
    always_comb begin
        timer_d = timer_q;
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (state_q == StShift || state_q == StBlank || state_q == StDisplay) begin
            timer_d = timer_q + TIMER_W'(1);
        end

        phase_d = '0;
        if (state_q == StShift && state_d == StShift) begin
            phase_d = (phase_q == PH_W'(2 * CLK_DIV - 1)) ? '0 : phase_q + PH_W'(1);
        end

        row_d = row_q;
        if (state_q == StIdle) begin
            // Re-enable always restarts at row pair 0.
            row_d = '0;
        end else if (state_q == StDisplay && timer_q == disp_last) begin
            row_d = (row_q == ROW_W'(HALF - 1)) ? '0 : row_q + ROW_W'(1);
        end
    end

    // Timer, phase and row registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_q <= '0;
            phase_q <= '0;
            row_q   <= '0;
        end else begin
            timer_q <= timer_d;
            phase_q <= phase_d;
            row_q   <= row_d;
        end
    end

    // Panel row address changes only while blanked, on the first BLANK cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            panel_addr <= '0;
        end else if (state_q == StBlank && timer_q == '0) begin
            panel_addr <= row_q;
        end
    end

    led_shift_pair #(
        .COLS (COLS)
    ) u_shift_pair (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_u (load_u),
        .load_l (load_l),
        .shift  (shift),
        .din    (fb_data),
        .r1     (panel_r1),
        .r2     (panel_r2)
    );

endmodule

// File: tb/tb_led_panel_scan.sv
// tb_led_panel_scan: randomized framebuffer contents checked against a step-level panel model.
module tb_led_panel_scan;

    localparam int COLS      = 64;
    localparam int ROWS      = 64;
    localparam int HALF      = 32;
    localparam int CLK_DIV   = 2;
    localparam int BLANK     = 2;
    localparam int DISP      = 256;
    localparam int STEP      = 3 + COLS * 2 * CLK_DIV + BLANK + 1 + DISP;
    localparam int FIRST_LAT = 3 + COLS * 2 * CLK_DIV + BLANK;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [5:0]  fb_addr;
    logic [63:0] fb_data;
    logic        panel_r1, panel_r2, panel_clk, panel_lat, panel_oe_n, frame_start;
    logic [4:0]  panel_addr;
`ifdef LED_SCAN_BRIGHTNESS_EN
    logic [2:0]  brightness = 3'd7;
`endif

    logic [63:0] fb [ROWS];
    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Monitor state: what the panel has latched, step by step.
    logic [63:0] lat_u_q [$];
    logic [63:0] lat_l_q [$];
    int          lat_addr_q [$];
    int          lat_rise_q [$];
    int          lat_cyc_q [$];
    int          oe_q [$];
    int          fs_q [$];
    logic [63:0] sh_u, sh_l;
    int          rise_cnt, oe_cnt;
    logic        prev_pclk;

    led_panel_scan dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
`ifdef LED_SCAN_BRIGHTNESS_EN
        .brightness  (brightness),
`endif
        .fb_addr     (fb_addr),
        .fb_data     (fb_data),
        .panel_r1    (panel_r1),
        .panel_r2    (panel_r2),
        .panel_clk   (panel_clk),
        .panel_lat   (panel_lat),
        .panel_oe_n  (panel_oe_n),
        .panel_addr  (panel_addr),
        .frame_start (frame_start)
    );

    always #5 clk = ~clk;

    // Registered framebuffer: data valid one cycle after the address.
    always @(posedge clk) fb_data <= fb[fb_addr];

    always @(posedge clk) cyc <= cyc + 1;

    // Panel-side view: shift bits in on each panel_clk rise, record on latch.
    always @(negedge clk) begin
        if (!rst_n) begin
            rise_cnt = 0; sh_u = '0; sh_l = '0; oe_cnt = 0; prev_pclk = 1'b0;
        end else begin
            if (panel_clk && !prev_pclk) begin
                if (rise_cnt < COLS) begin
                    sh_u[rise_cnt] = panel_r1;
                    sh_l[rise_cnt] = panel_r2;
                end
                rise_cnt++;
            end
            prev_pclk = panel_clk;
            if (panel_lat) begin
                lat_u_q.push_back(sh_u);
                lat_l_q.push_back(sh_l);
                lat_addr_q.push_back(int'(panel_addr));
                lat_rise_q.push_back(rise_cnt);
                lat_cyc_q.push_back(cyc);
                rise_cnt = 0; sh_u = '0; sh_l = '0;
            end
            if (!panel_oe_n) oe_cnt++;
            else if (oe_cnt != 0) begin
                oe_q.push_back(oe_cnt);
                oe_cnt = 0;
            end
            if (frame_start) fs_q.push_back(cyc);
        end
    end

    task automatic fill_fb();
        for (int r = 0; r < ROWS; r++) fb[r] = {$urandom, $urandom};
    endtask

    task automatic clear_queues();
        lat_u_q.delete(); lat_l_q.delete(); lat_addr_q.delete(); lat_rise_q.delete();
        lat_cyc_q.delete(); oe_q.delete(); fs_q.delete();
    endtask

    task automatic do_reset(input logic en);
        @(negedge clk);
        rst_n = 1'b0;
        enable = en;
        clear_queues();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_lat(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (lat_addr_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit seen;
        int n;
        fill_fb();
        fb[0]  = 64'h1;
        fb[32] = 64'h8000_0000_0000_0000;
        @(negedge clk);
        rst_n = 1'b0;
        enable = 1'b1;
        clear_queues();
        repeat (3) @(negedge clk);
        checks++;
        if (panel_oe_n !== 1'b1 || panel_lat !== 1'b0 || panel_clk !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: oe_n=%b lat=%b clk=%b required 1 0 0",
                     panel_oe_n, panel_lat, panel_clk);
        end
        checks++;
        if (fb_addr !== 6'd0 || panel_addr !== 5'd0 || frame_start !== 1'b0) begin
            failures++;
            $display("FAIL reset_addr: fb_addr=%0d panel_addr=%0d fs=%b required 0 0 0",
                     fb_addr, panel_addr, frame_start);
        end
        checks++;
        if (panel_r1 !== 1'b0 || panel_r2 !== 1'b0) begin
            failures++;
            $display("FAIL reset_data: r1=%b r2=%b required 0 0", panel_r1, panel_r2);
        end
        rst_n = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clk);
            if (frame_start === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL first_frame_start: got none required pulse within 8 cycles");
        end
        checks++;
        if (fb_addr !== 6'd0) begin
            failures++;
            $display("FAIL fetch_upper_addr: got %0d required 0", fb_addr);
        end
        @(negedge clk);
        checks++;
        if (fb_addr !== 6'd32 || frame_start !== 1'b0) begin
            failures++;
            $display("FAIL fetch_lower_addr: got %0d fs=%b required 32 fs=0", fb_addr, frame_start);
        end
        n = 1;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            n++;
            if (panel_lat === 1'b1) break;
        end
        checks++;
        if (n != FIRST_LAT) begin
            failures++;
            $display("FAIL first_latch_cycle: got %0d required %0d", n, FIRST_LAT);
        end
    endtask

    task automatic test_shift_data();
        bit ok;
        wait_lat(1, 10, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL shift_latch_seen: got no latch required one");
            return;
        end
        checks++;
        if (lat_u_q[0] !== 64'h1) begin
            failures++;
            $display("FAIL shift_r1: got %h required %h", lat_u_q[0], 64'h1);
        end
        checks++;
        if (lat_l_q[0] !== 64'h8000_0000_0000_0000) begin
            failures++;
            $display("FAIL shift_r2: got %h required %h", lat_l_q[0], 64'h8000_0000_0000_0000);
        end
        checks++;
        if (lat_rise_q[0] != COLS) begin
            failures++;
            $display("FAIL shift_rises: got %0d required %0d", lat_rise_q[0], COLS);
        end
        checks++;
        if (fs_q.size() != 1) begin
            failures++;
            $display("FAIL frame_start_count: got %0d required 1", fs_q.size());
        end
    endtask

    task automatic test_full_frame();
        bit ok;
        int r;
        wait_lat(HALF + 1, (HALF + 1) * STEP + 200, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL frame_latches: got %0d required %0d", lat_addr_q.size(), HALF + 1);
            return;
        end
        for (int i = 0; i <= HALF; i++) begin
            r = i % HALF;
            checks++;
            if (lat_addr_q[i] != r) begin
                failures++;
                $display("FAIL frame_addr[%0d]: got %0d required %0d", i, lat_addr_q[i], r);
            end
            checks++;
            if (lat_u_q[i] !== fb[r] || lat_l_q[i] !== fb[r + HALF]) begin
                failures++;
                $display("FAIL frame_data[%0d]: got %h/%h required %h/%h", i, lat_u_q[i],
                         lat_l_q[i], fb[r], fb[r + HALF]);
            end
            checks++;
            if (lat_rise_q[i] != COLS) begin
                failures++;
                $display("FAIL frame_rises[%0d]: got %0d required %0d", i, lat_rise_q[i], COLS);
            end
            if (i > 0) begin
                checks++;
                if (lat_cyc_q[i] - lat_cyc_q[i - 1] != STEP) begin
                    failures++;
                    $display("FAIL step_period[%0d]: got %0d required %0d", i,
                             lat_cyc_q[i] - lat_cyc_q[i - 1], STEP);
                end
            end
            if (i < HALF) begin
                checks++;
                if (oe_q[i] != DISP) begin
                    failures++;
                    $display("FAIL on_time[%0d]: got %0d required %0d", i, oe_q[i], DISP);
                end
            end
        end
        checks++;
        if (fs_q.size() != 2) begin
            failures++;
            $display("FAIL frame_start_pulses: got %0d required 2", fs_q.size());
        end else begin
            checks++;
            if (fs_q[1] - fs_q[0] != HALF * STEP) begin
                failures++;
                $display("FAIL frame_period: got %0d required %0d", fs_q[1] - fs_q[0], HALF * STEP);
            end
        end
    endtask

    task automatic test_enable_drop();
        bit ok, seen;
        int pair, bad;
        fill_fb();
        do_reset(1'b1);
        pair = $urandom_range(3, 7);
        wait_lat(pair, (pair + 1) * STEP, ok);
        seen = 1'b0;
        for (int k = 0; k < 2 * STEP && !seen; k++) begin
            @(negedge clk);
            if (panel_clk === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!ok || !seen) begin
            failures++;
            $display("FAIL drop_reach_shift: got ok=%0d seen=%0d required 1 1", ok, seen);
            return;
        end
        enable = 1'b0;
        wait_lat(pair + 1, 2 * STEP, ok);
        for (int k = 0; k < 2 * STEP && oe_q.size() < pair + 1; k++) @(posedge clk);
        checks++;
        if (!ok || oe_q.size() < pair + 1) begin
            failures++;
            $display("FAIL drop_step_complete: got latches=%0d displays=%0d required %0d",
                     lat_addr_q.size(), oe_q.size(), pair + 1);
            return;
        end
        checks++;
        if (lat_addr_q[pair] != pair || lat_u_q[pair] !== fb[pair]) begin
            failures++;
            $display("FAIL drop_last_step: got addr %0d data %h required %0d %h",
                     lat_addr_q[pair], lat_u_q[pair], pair, fb[pair]);
        end
        checks++;
        if (oe_q[pair] != DISP) begin
            failures++;
            $display("FAIL drop_on_time: got %0d required %0d", oe_q[pair], DISP);
        end
        bad = 0;
        for (int k = 0; k < 2 * STEP; k++) begin
            @(negedge clk);
            if (panel_lat !== 1'b0 || panel_oe_n !== 1'b1 || frame_start !== 1'b0 ||
                panel_clk !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0 || lat_addr_q.size() != pair + 1) begin
            failures++;
            $display("FAIL idle_quiet: got %0d active cycles, %0d latches required 0, %0d",
                     bad, lat_addr_q.size(), pair + 1);
        end
        enable = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 4 && !seen; k++) begin
            @(negedge clk);
            if (frame_start === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || fb_addr !== 6'd0) begin
            failures++;
            $display("FAIL reenable_start: got fs=%0d fb_addr=%0d required 1 0", seen, fb_addr);
        end
        wait_lat(pair + 2, 2 * STEP, ok);
        checks++;
        if (!ok || lat_addr_q[pair + 1] != 0 || lat_u_q[pair + 1] !== fb[0]) begin
            failures++;
            $display("FAIL reenable_row0: got ok=%0d addr=%0d required ok=1 addr=0", ok,
                     ok ? lat_addr_q[pair + 1] : -1);
        end
    endtask

    task automatic test_reset_mid_display();
        bit ok, seen;
        fill_fb();
        do_reset(1'b1);
        wait_lat(2, 3 * STEP, ok);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (panel_oe_n === 1'b0) seen = 1'b1;
        end
        checks++;
        if (!ok || !seen || panel_addr !== 5'd1) begin
            failures++;
            $display("FAIL mid_display_setup: got ok=%0d disp=%0d addr=%0d required 1 1 1",
                     ok, seen, panel_addr);
            return;
        end
        repeat ($urandom_range(0, 200)) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (panel_oe_n !== 1'b1 || panel_lat !== 1'b0 || panel_clk !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_ctrl: oe_n=%b lat=%b clk=%b required 1 0 0",
                     panel_oe_n, panel_lat, panel_clk);
        end
        checks++;
        if (panel_addr !== 5'd0 || fb_addr !== 6'd0 || frame_start !== 1'b0) begin
            failures++;
            $display("FAIL async_reset_addr: panel_addr=%0d fb_addr=%0d fs=%b required 0 0 0",
                     panel_addr, fb_addr, frame_start);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

`ifdef LED_SCAN_BRIGHTNESS_EN
    task automatic test_brightness();
        bit ok;
        int b, exp_on;
        int blist [4];
        blist[0] = 3;
        blist[1] = 0;
        blist[2] = $urandom_range(0, 7);
        blist[3] = $urandom_range(0, 7);
        for (int t = 0; t < 4; t++) begin
            b = blist[t];
            brightness = 3'(b);
            exp_on = (b + 1) * DISP / 8;
            do_reset(1'b1);
            wait_lat(3, 4 * STEP, ok);
            for (int k = 0; k < STEP && oe_q.size() < 2; k++) @(posedge clk);
            checks++;
            if (!ok || oe_q.size() < 2) begin
                failures++;
                $display("FAIL bright_steps[%0d]: got %0d displays required 2", b, oe_q.size());
            end else begin
                checks++;
                if (oe_q[0] != exp_on || oe_q[1] != exp_on) begin
                    failures++;
                    $display("FAIL bright_on_time[%0d]: got %0d/%0d required %0d", b, oe_q[0],
                             oe_q[1], exp_on);
                end
            end
        end
        brightness = 3'd7;
    endtask
`endif

    initial begin
        rst_n = 1'b1;
        enable = 1'b0;
        test_reset();
        test_shift_data();
        test_full_frame();
        test_enable_drop();
        test_reset_mid_display();
`ifdef LED_SCAN_BRIGHTNESS_EN
        test_brightness();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1, "watchdog");
    end

endmodule
